// File: rtl/uart_rx_fifo.sv
// UART receiver: input synchroniser, 16x-oversampled receive FSM with 3-sample majority vote, and receive FIFO.
// Optional macro UART_RX_ADDR_DETECT_EN enables 9-bit address detection (aden); without it aden is storage only.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  input  logic       rx_sample_en,
  input  logic [7:0] reg_data_in,
  input  logic       rcsta_reg_wr_en,
  output logic [7:0] rcsta_reg_out,
  input  logic       rcreg_rd_en,
  output logic [7:0] rcreg_reg_out,
  output logic       rxif_set_en,
  output logic       rx_busy,
  output logic [2:0] rx_state_dbg_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_NINTH = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   prev_q;
  logic                   rx9_q, cren_q, aden_q, oerr_q;
  logic                   cren_clear;
  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [1:0]             vote_q;
  logic [7:0]             shift_q;
  logic                   bit9_q;
  logic                   maj;
  logic                   keep_frame;
  logic                   push_q;
  logic [9:0]             push_data_q;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic                   full, pop, do_push, overflow;
  logic [9:0]             head;

  // RXD is asynchronous; only the last synchroniser stage is ever observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
  end
  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx9_q  <= 1'b0;
      cren_q <= 1'b0;
      aden_q <= 1'b0;
    end else if (rcsta_reg_wr_en) begin
      rx9_q  <= reg_data_in[6];
      cren_q <= reg_data_in[4];
      aden_q <= reg_data_in[3];
    end
  end

  assign cren_clear = rcsta_reg_wr_en & ~reg_data_in[4];
  // samples 7 and 8 sit in vote_q, sample 9 is the live input
  assign maj = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);

`ifdef UART_RX_ADDR_DETECT_EN
  assign keep_frame = ~(aden_q & rx9_q & ~bit9_q);
`else
  assign keep_frame = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prev_q      <= 1'b1;
      cnt_q       <= 4'd1;
      bit_cnt_q   <= 3'd0;
      vote_q      <= 2'b11;
      shift_q     <= 8'h00;
      bit9_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 10'h000;
    end else begin
      push_q <= 1'b0;
      if (rx_sample_en) prev_q <= rxd_s;
      if (cren_clear) begin
        state_q <= S_IDLE;
        cnt_q   <= 4'd1;
      end else if (rx_sample_en) begin
        if (cnt_q == 4'd7 || cnt_q == 4'd8) vote_q <= {vote_q[0], rxd_s};
        cnt_q <= cnt_q + 4'd1;
        case (state_q)
          S_IDLE: begin
            // the sample that sees the falling edge counts as sample 0
            cnt_q <= 4'd1;
            if (cren_q && !oerr_q && prev_q && !rxd_s) begin
              state_q   <= S_START;
              bit_cnt_q <= 3'd0;
              bit9_q    <= 1'b0;
            end
          end
          S_START: begin
            if (cnt_q == 4'd9 && maj)  state_q <= S_IDLE;
            else if (cnt_q == 4'd15)   state_q <= S_DATA;
          end
          S_DATA: begin
            if (cnt_q == 4'd9) shift_q <= {maj, shift_q[7:1]};
            if (cnt_q == 4'd15) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= rx9_q ? S_NINTH : S_STOP;
            end
          end
          S_NINTH: begin
            if (cnt_q == 4'd9)  bit9_q  <= maj;
            if (cnt_q == 4'd15) state_q <= S_STOP;
          end
          S_STOP: begin
            if (cnt_q == 4'd9) begin
              state_q     <= S_IDLE;
              push_q      <= keep_frame;
              push_data_q <= {~maj, bit9_q & rx9_q, shift_q};
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_busy        = (state_q != S_IDLE);
  assign rx_state_dbg_o = state_q;

  assign full     = (count_q == DEPTH_C);
  assign pop      = rcreg_rd_en && (count_q != '0);
  assign do_push  = push_q && (!full || pop);
  assign overflow = push_q && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      oerr_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // clearing cren wins over a simultaneous overrun
      if (cren_clear)    oerr_q <= 1'b0;
      else if (overflow) oerr_q <= 1'b1;
    end
  end

  assign head          = (count_q != '0) ? mem[rd_ptr_q] : 10'h000;
  assign rxif_set_en   = (count_q != '0);
  assign rcreg_reg_out = head[7:0];
  assign rcsta_reg_out = {1'b1, rx9_q, 1'b0, cren_q, aden_q, head[9], oerr_q, head[8]};

endmodule
